// File: rtl/time_surface_scanner.sv
// Read-side master for the time-surface store: sweeps every grid cell through
// the store's registered read port and streams the decayed values downstream.
module time_surface_scanner #(
  parameter int GRID_SIZE    = 16,
  parameter int ADDR_BITS    = 8,
  parameter int TS_BITS      = 16,
  parameter int VALUE_BITS   = 8,
  parameter int READ_LATENCY = 3,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic [TS_BITS-1:0]                t_now_in,
  output logic [TS_BITS-1:0]                frame_t_now,
  output logic                              read_enable,
  output logic [ADDR_BITS-1:0]              read_addr,
  input  logic [VALUE_BITS-1:0]             read_value,
  output logic                              m_valid,
  input  logic                              m_ready,
  output logic [VALUE_BITS-1:0]             m_data,
  output logic [$clog2(GRID_SIZE)-1:0]      m_x,
  output logic [$clog2(GRID_SIZE)-1:0]      m_y,
  output logic                              m_last,
  output logic                              busy,
  output logic                              done,
  output logic [VALUE_BITS+ADDR_BITS:0]     frame_sum
);

  localparam int NUM_CELLS = GRID_SIZE * GRID_SIZE;
  localparam int XY_BITS   = $clog2(GRID_SIZE);
  localparam int SUM_BITS  = VALUE_BITS + ADDR_BITS + 1;
  localparam int CNT_W     = $clog2(FIFO_DEPTH + 1) + 1;
  localparam int PTR_W     = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(NUM_CELLS - 1);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_DONE} state_e;

  typedef struct packed {
    logic [VALUE_BITS-1:0] data;
    logic [XY_BITS-1:0]    x;
    logic [XY_BITS-1:0]    y;
    logic                  last;
  } beat_t;

  state_e                                  state_q, state_d;
  logic [TS_BITS-1:0]                      frame_t_now_q, frame_t_now_d;
  logic                                    read_enable_q, read_enable_d;
  logic [ADDR_BITS-1:0]                    read_addr_q, read_addr_d;
  logic                                    busy_q, busy_d;
  logic                                    done_q, done_d;
  logic [SUM_BITS-1:0]                     frame_sum_q, frame_sum_d;
  logic [READ_LATENCY-1:0]                 pipe_valid_q, pipe_valid_d;
  logic [READ_LATENCY-1:0][ADDR_BITS-1:0]  pipe_addr_q, pipe_addr_d;
  beat_t [FIFO_DEPTH-1:0]                  fifo_mem_q, fifo_mem_d;
  logic [PTR_W-1:0]                        rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]                        wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]                        fifo_count_q, fifo_count_d;

  logic [CNT_W-1:0]     inflight;
  logic [CNT_W-1:0]     credit_used;
  logic                 pop;
  logic                 push;
  logic                 issue;
  logic [ADDR_BITS-1:0] tail_addr;
  beat_t                head;
  beat_t                tail_beat;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A beat popped this cycle frees its slot in time for a read issued now,
  // which keeps the sweep at one cell per cycle under full throughput.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      inflight = inflight + CNT_W'(pipe_valid_q[i]);
    end
    head        = fifo_mem_q[rd_ptr_q];
    pop         = (fifo_count_q != '0) && m_ready;
    push        = pipe_valid_q[READ_LATENCY-1];
    credit_used = fifo_count_q + inflight - CNT_W'(pop);
    issue       = (state_q == S_SCAN) && (credit_used < CNT_W'(FIFO_DEPTH));
    tail_addr   = pipe_addr_q[READ_LATENCY-1];

    tail_beat.data = read_value;
    tail_beat.x    = XY_BITS'(tail_addr % ADDR_BITS'(GRID_SIZE));
    tail_beat.y    = XY_BITS'(tail_addr / ADDR_BITS'(GRID_SIZE));
    tail_beat.last = (tail_addr == LAST_ADDR);

    pipe_valid_d    = {pipe_valid_q[READ_LATENCY-2:0], issue};
    pipe_addr_d     = {pipe_addr_q[READ_LATENCY-2:0], read_addr_q};
    fifo_mem_d      = fifo_mem_q;
    rd_ptr_d        = rd_ptr_q;
    wr_ptr_d        = wr_ptr_q;
    fifo_count_d    = fifo_count_q + CNT_W'(push) - CNT_W'(pop);
    if (push) begin
      fifo_mem_d[wr_ptr_q] = tail_beat;
      wr_ptr_d             = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end

    state_d       = state_q;
    frame_t_now_d = frame_t_now_q;
    read_enable_d = read_enable_q;
    read_addr_d   = read_addr_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    frame_sum_d   = pop ? frame_sum_q + SUM_BITS'(head.data) : frame_sum_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          frame_t_now_d = t_now_in;
          frame_sum_d   = '0;
          read_addr_d   = '0;
          busy_d        = 1'b1;
          read_enable_d = 1'b1;
          state_d       = S_SCAN;
        end
      end
      S_SCAN: begin
        if (issue) begin
          if (read_addr_q == LAST_ADDR) begin
            state_d = S_DRAIN;
          end else begin
            read_addr_d = read_addr_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if ((inflight == '0) && pop && head.last) begin
          state_d       = S_DONE;
          busy_d        = 1'b0;
          done_d        = 1'b1;
          read_enable_d = 1'b0;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      frame_t_now_q <= '0;
      read_enable_q <= 1'b0;
      read_addr_q   <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      frame_sum_q   <= '0;
      pipe_valid_q  <= '0;
      pipe_addr_q   <= '0;
      fifo_mem_q    <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      fifo_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      frame_t_now_q <= frame_t_now_d;
      read_enable_q <= read_enable_d;
      read_addr_q   <= read_addr_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      frame_sum_q   <= frame_sum_d;
      pipe_valid_q  <= pipe_valid_d;
      pipe_addr_q   <= pipe_addr_d;
      fifo_mem_q    <= fifo_mem_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      fifo_count_q  <= fifo_count_d;
    end
  end

  assign frame_t_now = frame_t_now_q;
  assign read_enable = read_enable_q;
  assign read_addr   = read_addr_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign frame_sum   = frame_sum_q;
  assign m_valid     = (fifo_count_q != '0);
  assign m_data      = head.data;
  assign m_x         = head.x;
  assign m_y         = head.y;
  assign m_last      = head.last;

endmodule

// File: tb/tb_time_surface_scanner.sv
// Bench for time_surface_scanner: a latency-3 store model feeds the scanner and
// every beat is scored against the cell sequence expected from the grid sweep.
module tb_time_surface_scanner;

  localparam int GRID   = 16;
  localparam int NCELLS = GRID * GRID;
  localparam int DEPTH  = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] t_now_in;
  logic [15:0] frame_t_now;
  logic        read_enable;
  logic [7:0]  read_addr;
  logic [7:0]  read_value;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  m_data;
  logic [3:0]  m_x;
  logic [3:0]  m_y;
  logic        m_last;
  logic        busy;
  logic        done;
  logic [16:0] frame_sum;

  logic [7:0]  salt = 8'h00;
  logic [7:0]  store_s1 = 8'h00;
  logic [7:0]  store_s2 = 8'h00;
  logic [7:0]  store_s3 = 8'h00;

  int cyc = 0;
  int assertions_evaluated = 0;
  int failures = 0;

  time_surface_scanner dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .t_now_in    (t_now_in),
    .frame_t_now (frame_t_now),
    .read_enable (read_enable),
    .read_addr   (read_addr),
    .read_value  (read_value),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .m_x         (m_x),
    .m_y         (m_y),
    .m_last      (m_last),
    .busy        (busy),
    .done        (done),
    .frame_sum   (frame_sum)
  );

  always #5 clk = ~clk;

  // Store returns cell value (addr ^ salt) three cycles after the address.
  always @(posedge clk) begin
    if (read_enable) begin
      store_s1 <= read_addr;
      store_s2 <= store_s1;
      store_s3 <= store_s2;
    end
  end
  assign read_value = store_s3 ^ salt;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    assertions_evaluated++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic check_reset_state();
    check_output("rst_frame_t_now", frame_t_now, 0);
    check_output("rst_read_enable", read_enable, 0);
    check_output("rst_read_addr", read_addr, 0);
    check_output("rst_m_valid", m_valid, 0);
    check_output("rst_m_data", m_data, 0);
    check_output("rst_m_x", m_x, 0);
    check_output("rst_m_y", m_y, 0);
    check_output("rst_m_last", m_last, 0);
    check_output("rst_busy", busy, 0);
    check_output("rst_done", done, 0);
    check_output("rst_frame_sum", frame_sum, 0);
  endtask

  // mode 0: ready always high; 1: ready low for 20 cycles at beat hold_at;
  // 2: ready high with 30% probability. Called at a negedge.
  task automatic apply_stimulus(input int mode, input logic [7:0] salt_in,
                                input logic [15:0] t_start, input int hold_at,
                                input int pulse_at, input int reset_at,
                                input bit start_in_done);
    int          acc = 0;
    int          start_cyc;
    int          hold_remain = 0;
    bit          hold_used = 0;
    bit          pulsed = 0;
    bit          held = 0;
    bit          done_seen = 0;
    logic [16:0] sum_model = '0;
    logic [7:0]  exp_data;
    logic [7:0]  held_data;
    logic [3:0]  held_x;
    logic [3:0]  held_y;
    logic        held_last;

    salt      = salt_in;
    t_now_in  = t_start;
    start     = 1'b1;
    m_ready   = (mode != 2);
    start_cyc = cyc;
    $display("[TB] frame mode=%0d salt=0x%0h t_start=0x%0h at cycle %0d", mode, salt_in, t_start, cyc);

    for (int w = 0; w < 4000 && !done_seen; w++) begin
      @(negedge clk);
      cyc++;
      start    = 1'b0;
      t_now_in = t_now_in + 16'd1;
      if (mode == 1 && acc == hold_at && !hold_used) begin
        hold_used   = 1;
        hold_remain = 20;
      end
      case (mode)
        0: m_ready = 1'b1;
        1: begin
          if (hold_remain > 0) begin
            m_ready = 1'b0;
            hold_remain--;
          end else begin
            m_ready = 1'b1;
          end
        end
        default: m_ready = ($urandom_range(0, 99) < 30);
      endcase
      if (acc == pulse_at && !pulsed) begin
        pulsed = 1;
        start  = 1'b1;
      end
      #1;

      if (cyc == start_cyc + 1) begin
        check_output("first_read_addr", read_addr, 0);
        check_output("first_read_enable", read_enable, 1);
        check_output("first_busy", busy, 1);
      end
      if (busy) begin
        check_output("frame_t_now_const", frame_t_now, t_start);
        check_output("read_enable_held", read_enable, 1);
        check_output("outstanding_le_depth", 32'((int'(read_addr) - acc) <= DEPTH), 1);
      end
      if (held) begin
        check_output("held_valid", m_valid, 1);
        check_output("held_data", m_data, held_data);
        check_output("held_x", m_x, held_x);
        check_output("held_y", m_y, held_y);
        check_output("held_last", m_last, held_last);
      end
      if (m_valid && m_ready) begin
        exp_data = 8'(acc) ^ salt_in;
        check_output("beat_data", m_data, exp_data);
        check_output("beat_x", m_x, acc % GRID);
        check_output("beat_y", m_y, acc / GRID);
        check_output("beat_last", m_last, 32'(acc == NCELLS - 1));
        if (mode == 0) check_output("beat_cycle", cyc, start_cyc + 5 + acc);
        sum_model = sum_model + 17'(exp_data);
        acc++;
        if (acc == reset_at) begin
          #2 rst_n = 1'b0;
          #1 check_reset_state();
          repeat (2) begin
            @(negedge clk);
            cyc++;
            #1 check_reset_state();
          end
          rst_n = 1'b1;
          return;
        end
      end
      held      = m_valid && !m_ready;
      held_data = m_data;
      held_x    = m_x;
      held_y    = m_y;
      held_last = m_last;
      if (done) begin
        done_seen = 1;
        check_output("done_beats", acc, NCELLS);
        check_output("done_frame_sum", frame_sum, sum_model);
        check_output("done_busy_low", busy, 0);
        if (mode == 0) check_output("done_cycle", cyc, start_cyc + 261);
      end
    end
    if (!done_seen) begin
      check_output("frame_timeout", 0, 1);
      return;
    end

    if (start_in_done) start = 1'b1;
    @(negedge clk);
    cyc++;
    start = 1'b0;
    #1;
    check_output("done_single_pulse", done, 0);
    check_output("idle_busy", busy, 0);
    check_output("sum_hold", frame_sum, sum_model);
    @(negedge clk);
    cyc++;
    #1;
    check_output("idle_busy_later", busy, 0);
    check_output("idle_done_later", done, 0);
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    m_ready  = 1'b0;
    t_now_in = 16'h0000;
    repeat (3) begin
      @(negedge clk);
      cyc++;
    end
    #1 check_reset_state();
    rst_n = 1'b1;
    while (cyc < 10) begin
      @(negedge clk);
      cyc++;
    end

    apply_stimulus(0, 8'h00, 16'h1234, -1, -1, -1, 0);
    apply_stimulus(1, 8'h5A, 16'hFFF0, 5, 100, -1, 1);
    apply_stimulus(2, 8'($urandom), 16'($urandom), -1, -1, -1, 0);
    apply_stimulus(0, 8'hC3, 16'h0100, -1, -1, 50, 0);
    apply_stimulus(0, 8'h33, 16'h0042, -1, -1, -1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions_evaluated, failures);
    $finish;
  end

endmodule
